dsi_pkt_scheduler: RTL

Sequencing controller in front of the DSI packetizer. It arbitrates between a command requester (short packets) and a video-line requester (long packets), latches the winning packet header, and launches the ECC, CRC and pixel-FIFO engines. It collects their done pulses, fires the packetizer, and waits for `packet_done`, with a watchdog on every wait.

---
 rtl/dsi_pkt_scheduler.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/dsi_pkt_scheduler.sv
// dsi_pkt_scheduler
// Sequencing controller in front of the DSI packetizer. It arbitrates between a
// command requester (short packets) and a video-line requester (long packets),
// latches the winning header, launches the ECC/CRC/FIFO engines, collects their
// done pulses, fires the packetizer and waits for packet_done. Every wait is
// guarded by a watchdog.
//
// Ports:
//   dsi_clk, dsi_rst_n              clock, asynchronous active-low reset
//   cmd_req/cmd_dt/cmd_data/cmd_ack short-packet request, header fields, accept pulse
//   vid_req/vid_dt/vid_wc/vid_ack   long-packet request, header fields, accept pulse
//   hdr_dt/hdr_wc/pkt_long          latched header of the packet in flight
//   ecc/crc/fifo_start              one-cycle engine launch pulses
//   ecc/crc/fifo_done               engine completion pulses
//   pkt_go, packet_done             packetizer fire pulse and its completion
//   busy                            high whenever the controller is not idle
//   timeout_err, clr_err            sticky watchdog flag and its clear
// All outputs come straight from flops.
module dsi_pkt_scheduler #(
  parameter int MAX_CMD_BURST = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic        dsi_clk,
  input  logic        dsi_rst_n,
  input  logic        cmd_req,
  input  logic [7:0]  cmd_dt,
  input  logic [15:0] cmd_data,
  output logic        cmd_ack,
  input  logic        vid_req,
  input  logic [7:0]  vid_dt,
  input  logic [15:0] vid_wc,
  output logic        vid_ack,
  output logic [7:0]  hdr_dt,
  output logic [15:0] hdr_wc,
  output logic        pkt_long,
  output logic        ecc_start,
  output logic        crc_start,
  output logic        fifo_start,
  input  logic        ecc_done,
  input  logic        crc_done,
  input  logic        fifo_done,
  output logic        pkt_go,
  input  logic        packet_done,
  output logic        busy,
  output logic        timeout_err,
  input  logic        clr_err
);

  localparam int BW = (MAX_CMD_BURST >= 1) ? $clog2(MAX_CMD_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_CMD_BURST);
  // Watchdog fires in the TIMEOUT-th counted cycle, i.e. when the count is TIMEOUT-1.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_COLLECT = 3'd2,
    S_EMIT    = 3'd3,
    S_WAIT    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [7:0]    wd_q, wd_d;
  logic          ecc_got_q, ecc_got_d, crc_got_q, crc_got_d, fifo_got_q, fifo_got_d;
  logic [7:0]    hdr_dt_q, hdr_dt_d;
  logic [15:0]   hdr_wc_q, hdr_wc_d;
  logic          pkt_long_q, pkt_long_d;
  logic          cmd_ack_q, cmd_ack_d, vid_ack_q, vid_ack_d;
  logic          ecc_start_q, ecc_start_d, crc_start_q, crc_start_d;
  logic          fifo_start_q, fifo_start_d, pkt_go_q, pkt_go_d;
  logic          busy_q, busy_d, err_q, err_d;

  logic          vid_wins_s, ecc_all_s, crc_all_s, fifo_all_s, complete_s, set_err_s;

  // Next-state, arbitration, watchdog and registered-output computation.
  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    wd_d         = wd_q;
    ecc_got_d    = ecc_got_q;
    crc_got_d    = crc_got_q;
    fifo_got_d   = fifo_got_q;
    hdr_dt_d     = hdr_dt_q;
    hdr_wc_d     = hdr_wc_q;
    pkt_long_d   = pkt_long_q;
    cmd_ack_d    = 1'b0;
    vid_ack_d    = 1'b0;
    ecc_start_d  = 1'b0;
    crc_start_d  = 1'b0;
    fifo_start_d = 1'b0;
    pkt_go_d     = 1'b0;
    set_err_s    = 1'b0;
    // Video overrides the command priority once the burst allowance is used up.
    vid_wins_s   = vid_req && (!cmd_req || (burst_q == BURST_MAX));
    ecc_all_s    = ecc_got_q | ecc_done;
    crc_all_s    = crc_got_q | crc_done;
    fifo_all_s   = fifo_got_q | fifo_done;
    complete_s   = ecc_all_s && (!pkt_long_q || (crc_all_s && fifo_all_s));

    case (state_q)
      S_IDLE: begin
        if (cmd_req || vid_req) begin
          state_d     = S_LAUNCH;
          ecc_start_d = 1'b1;
          if (vid_wins_s) begin
            vid_ack_d    = 1'b1;
            crc_start_d  = 1'b1;
            fifo_start_d = 1'b1;
            hdr_dt_d     = vid_dt;
            hdr_wc_d     = vid_wc;
            pkt_long_d   = 1'b1;
            burst_d      = '0;
          end else begin
            cmd_ack_d  = 1'b1;
            hdr_dt_d   = cmd_dt;
            hdr_wc_d   = cmd_data;
            pkt_long_d = 1'b0;
            // Only count short packets that actually made video wait.
            burst_d    = vid_req ? (burst_q + BW'(1)) : '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        // Fresh capture discards any flags left over from the previous packet.
        ecc_got_d  = ecc_done;
        crc_got_d  = crc_done;
        fifo_got_d = fifo_done;
        wd_d       = 8'd0;
        state_d    = S_COLLECT;
      end
      S_COLLECT: begin
        ecc_got_d  = ecc_all_s;
        crc_got_d  = crc_all_s;
        fifo_got_d = fifo_all_s;
        if (complete_s) begin
          state_d  = S_EMIT;
          pkt_go_d = 1'b1;
          wd_d     = 8'd0;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_IDLE;
          set_err_s = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      S_EMIT: begin
        wd_d    = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (packet_done) begin
          state_d = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_IDLE;
          set_err_s = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    // A new expiry beats a simultaneous clear.
    if (set_err_s) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State, counters, flags and output registers.
  always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
    if (!dsi_rst_n) begin
      state_q      <= S_IDLE;
      burst_q      <= '0;
      wd_q         <= 8'd0;
      ecc_got_q    <= 1'b0;
      crc_got_q    <= 1'b0;
      fifo_got_q   <= 1'b0;
      hdr_dt_q     <= 8'd0;
      hdr_wc_q     <= 16'd0;
      pkt_long_q   <= 1'b0;
      cmd_ack_q    <= 1'b0;
      vid_ack_q    <= 1'b0;
      ecc_start_q  <= 1'b0;
      crc_start_q  <= 1'b0;
      fifo_start_q <= 1'b0;
      pkt_go_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      wd_q         <= wd_d;
      ecc_got_q    <= ecc_got_d;
      crc_got_q    <= crc_got_d;
      fifo_got_q   <= fifo_got_d;
      hdr_dt_q     <= hdr_dt_d;
      hdr_wc_q     <= hdr_wc_d;
      pkt_long_q   <= pkt_long_d;
      cmd_ack_q    <= cmd_ack_d;
      vid_ack_q    <= vid_ack_d;
      ecc_start_q  <= ecc_start_d;
      crc_start_q  <= crc_start_d;
      fifo_start_q <= fifo_start_d;
      pkt_go_q     <= pkt_go_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ack     = cmd_ack_q;
  assign vid_ack     = vid_ack_q;
  assign hdr_dt      = hdr_dt_q;
  assign hdr_wc      = hdr_wc_q;
  assign pkt_long    = pkt_long_q;
  assign ecc_start   = ecc_start_q;
  assign crc_start   = crc_start_q;
  assign fifo_start  = fifo_start_q;
  assign pkt_go      = pkt_go_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule
